// File: rtl/dsp_exmem_wb_pipe.sv
// rtl/dsp_exmem_wb_pipe.sv - EX/MEM and MEM/WB registers with decode RAW hazard resolution
// Define DSP_FORWARD_EN to forward MEM/WB results to decode; otherwise matches raise hazard_stall.
module dsp_exmem_wb_pipe #(
  parameter int WORD_LEN  = 16,
  parameter int MODE_LEN  = 2,
  parameter int RADDR_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [WORD_LEN-1:0]  ex_alu_result,
  input  logic [WORD_LEN-1:0]  ex_data_s1,
  input  logic [WORD_LEN-1:0]  ex_data_s2,
  input  logic [MODE_LEN-1:0]  ex_mem_mode,
  input  logic                 ex_write_back_en,
  input  logic [RADDR_LEN-1:0] ex_dest,
  input  logic                 stall,
  input  logic                 flush,
  output logic [WORD_LEN-1:0]  mem_alu_result,
  output logic [WORD_LEN-1:0]  mem_data_s1,
  output logic [WORD_LEN-1:0]  mem_data_s2,
  output logic [MODE_LEN-1:0]  mem_mode,
  output logic                 mem_write_back_en,
  output logic                 mem_valid,
  input  logic [WORD_LEN-1:0]  mem_write_back,
  input  logic                 mem_regfile_we,
  output logic                 wb_we,
  output logic [RADDR_LEN-1:0] wb_dest,
  output logic [WORD_LEN-1:0]  wb_data,
  input  logic [RADDR_LEN-1:0] id_rs1,
  input  logic [RADDR_LEN-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [WORD_LEN-1:0]  id_rs1_data,
  input  logic [WORD_LEN-1:0]  id_rs2_data,
  output logic [WORD_LEN-1:0]  fwd_rs1_data,
  output logic [WORD_LEN-1:0]  fwd_rs2_data,
  output logic                 hazard_stall
);

  localparam logic [MODE_LEN-1:0] MEM_NONE = '0;

  logic                 r_valid;
  logic [WORD_LEN-1:0]  r_alu;
  logic [WORD_LEN-1:0]  r_s1;
  logic [WORD_LEN-1:0]  r_s2;
  logic [MODE_LEN-1:0]  r_mode;
  logic                 r_wben;
  logic [RADDR_LEN-1:0] r_dest;

  logic                 r_wb_we;
  logic [RADDR_LEN-1:0] r_wb_dest;
  logic [WORD_LEN-1:0]  r_wb_data;

  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !ex_valid)) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_mode  <= MEM_NONE;
      r_wben  <= 1'b0;
      r_dest  <= '0;
    end else if (!stall) begin
      r_valid <= 1'b1;
      r_alu   <= ex_alu_result;
      r_s1    <= ex_data_s1;
      r_s2    <= ex_data_s2;
      r_mode  <= ex_mem_mode;
      r_wben  <= ex_write_back_en;
      r_dest  <= ex_dest;
    end
  end

  // WB never holds: a stalled MEM instruction feeds bubbles until it is released
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_dest <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_we   <= r_valid & mem_regfile_we & ~stall;
      r_wb_dest <= r_dest;
      r_wb_data <= mem_write_back;
    end
  end

  assign mem_valid         = r_valid;
  assign mem_alu_result    = r_alu;
  assign mem_data_s1       = r_s1;
  assign mem_data_s2       = r_s2;
  assign mem_mode          = r_mode;
  assign mem_write_back_en = r_wben & r_valid;
  assign wb_we             = r_wb_we;
  assign wb_dest           = r_wb_dest;
  assign wb_data           = r_wb_data;

  logic w_mem_hit1, w_mem_hit2, w_wb_hit1, w_wb_hit2;

  assign w_mem_hit1 = id_rs1_used & r_valid & mem_regfile_we & (r_dest == id_rs1);
  assign w_mem_hit2 = id_rs2_used & r_valid & mem_regfile_we & (r_dest == id_rs2);
  assign w_wb_hit1  = id_rs1_used & r_wb_we & (r_wb_dest == id_rs1);
  assign w_wb_hit2  = id_rs2_used & r_wb_we & (r_wb_dest == id_rs2);

`ifdef DSP_FORWARD_EN
  // The younger MEM result shadows the older WB result
  assign fwd_rs1_data = w_mem_hit1 ? mem_write_back : (w_wb_hit1 ? r_wb_data : id_rs1_data);
  assign fwd_rs2_data = w_mem_hit2 ? mem_write_back : (w_wb_hit2 ? r_wb_data : id_rs2_data);
  assign hazard_stall = 1'b0;
`else
  assign fwd_rs1_data = id_rs1_data;
  assign fwd_rs2_data = id_rs2_data;
  assign hazard_stall = w_mem_hit1 | w_mem_hit2 | w_wb_hit1 | w_wb_hit2;
`endif

endmodule

// File: tb/tb_dsp_exmem_wb_pipe.sv
// tb/tb_dsp_exmem_wb_pipe.sv - directed and randomized checks of dsp_exmem_wb_pipe against a slot model
module tb_dsp_exmem_wb_pipe;
  localparam int W = 16;
  localparam int M = 2;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid;
  logic [W-1:0] ex_alu_result, ex_data_s1, ex_data_s2;
  logic [M-1:0] ex_mem_mode;
  logic         ex_write_back_en;
  logic [R-1:0] ex_dest;
  logic         stall, flush;
  logic [W-1:0] mem_alu_result, mem_data_s1, mem_data_s2;
  logic [M-1:0] mem_mode;
  logic         mem_write_back_en, mem_valid;
  logic [W-1:0] mem_write_back;
  logic         mem_regfile_we;
  logic         wb_we;
  logic [R-1:0] wb_dest;
  logic [W-1:0] wb_data;
  logic [R-1:0] id_rs1, id_rs2;
  logic         id_rs1_used, id_rs2_used;
  logic [W-1:0] id_rs1_data, id_rs2_data;
  logic [W-1:0] fwd_rs1_data, fwd_rs2_data;
  logic         hazard_stall;

  dsp_exmem_wb_pipe #(.WORD_LEN(W), .MODE_LEN(M), .RADDR_LEN(R)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_data_s1(ex_data_s1), .ex_data_s2(ex_data_s2),
    .ex_mem_mode(ex_mem_mode), .ex_write_back_en(ex_write_back_en), .ex_dest(ex_dest),
    .stall(stall), .flush(flush),
    .mem_alu_result(mem_alu_result), .mem_data_s1(mem_data_s1), .mem_data_s2(mem_data_s2),
    .mem_mode(mem_mode), .mem_write_back_en(mem_write_back_en), .mem_valid(mem_valid),
    .mem_write_back(mem_write_back), .mem_regfile_we(mem_regfile_we),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  localparam logic [M-1:0] MEM_NONE = 2'd0;
  localparam logic [M-1:0] MEM_LD   = 2'd1;
  localparam logic [M-1:0] MEM_ST   = 2'd2;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] alu, s1, s2;
    logic [M-1:0] mode;
    logic         wben;
    logic [R-1:0] dest;
  } slot_t;

  slot_t        m_mem;
  logic         m_we;
  logic [R-1:0] m_dest;
  logic [W-1:0] m_data;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Producers still in flight, youngest first; decode sees the first one naming its source
  function automatic logic resolve(input logic used, input logic [R-1:0] rs, output logic [W-1:0] val);
    logic [R-1:0] pd[$];
    logic [W-1:0] pv[$];
    val = '0;
    if (m_mem.valid && mem_regfile_we) begin pd.push_back(m_mem.dest); pv.push_back(mem_write_back); end
    if (m_we) begin pd.push_back(m_dest); pv.push_back(m_data); end
    if (!used) return 1'b0;
    foreach (pd[i]) if (pd[i] == rs) begin val = pv[i]; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic check_all();
    logic h1, h2;
    logic [W-1:0] v1, v2;
    h1 = resolve(id_rs1_used, id_rs1, v1);
    h2 = resolve(id_rs2_used, id_rs2, v2);
    chk("mem_valid", W'(mem_valid), W'(m_mem.valid));
    chk("mem_mode", W'(mem_mode), W'(m_mem.mode));
    chk("mem_alu", mem_alu_result, m_mem.alu);
    chk("mem_s1", mem_data_s1, m_mem.s1);
    chk("mem_s2", mem_data_s2, m_mem.s2);
    chk("mem_wben", W'(mem_write_back_en), W'(m_mem.wben & m_mem.valid));
    chk("wb_we", W'(wb_we), W'(m_we));
    chk("wb_dest", W'(wb_dest), W'(m_dest));
    chk("wb_data", wb_data, m_data);
`ifdef DSP_FORWARD_EN
    chk("fwd1", fwd_rs1_data, h1 ? v1 : id_rs1_data);
    chk("fwd2", fwd_rs2_data, h2 ? v2 : id_rs2_data);
    chk("hazard", W'(hazard_stall), W'(0));
`else
    chk("fwd1", fwd_rs1_data, id_rs1_data);
    chk("fwd2", fwd_rs2_data, id_rs2_data);
    chk("hazard", W'(hazard_stall), W'(h1 | h2));
`endif
  endtask

  task automatic step();
    slot_t        n_mem;
    logic         n_we;
    logic [R-1:0] n_dest;
    logic [W-1:0] n_data;
    n_we   = !rst && m_mem.valid && mem_regfile_we && !stall;
    n_dest = rst ? '0 : m_mem.dest;
    n_data = rst ? '0 : mem_write_back;
    if (rst || flush) n_mem = '0;
    else if (stall) n_mem = m_mem;
    else if (ex_valid) n_mem = '{1'b1, ex_alu_result, ex_data_s1, ex_data_s2, ex_mem_mode, ex_write_back_en, ex_dest};
    else n_mem = '0;
    @(posedge clk);
    #1;
    m_mem = n_mem; m_we = n_we; m_dest = n_dest; m_data = n_data;
  endtask

  task automatic set_ex(input logic v, input logic [M-1:0] md, input logic wbe, input logic [R-1:0] d, input logic [W-1:0] a);
    ex_valid = v; ex_mem_mode = md; ex_write_back_en = wbe; ex_dest = d;
    ex_alu_result = a; ex_data_s1 = a ^ 16'h0F0F; ex_data_s2 = a + 16'd7;
  endtask

  initial begin
    m_mem = '0; m_we = 1'b0; m_dest = '0; m_data = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ex(1'b1, MEM_LD, 1'b1, 4'd9, 16'hBEEF);
    mem_write_back = 16'h0; mem_regfile_we = 1'b1;
    id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rs1_data = 16'h1111; id_rs2_data = 16'h2222;

    // reset held two cycles with a valid instruction presented
    step(); step();
    #1;
    chk("rst_mem_valid", W'(mem_valid), W'(0));
    chk("rst_mem_mode", W'(mem_mode), W'(MEM_NONE));
    chk("rst_wb_we", W'(wb_we), W'(0));
    chk("rst_hazard", W'(hazard_stall), W'(0));
    chk("rst_fwd1", fwd_rs1_data, 16'h1111);
    check_all();

    // simple ALU result to r3
    rst = 1'b0;
    set_ex(1'b1, MEM_NONE, 1'b1, 4'd3, 16'h1234);
    mem_regfile_we = 1'b0;
    step();
    set_ex(1'b0, MEM_NONE, 1'b0, 4'd0, 16'h0);
    mem_regfile_we = 1'b1; mem_write_back = 16'h1234;
    #1;
    chk("ld_mem_valid", W'(mem_valid), W'(1));
    chk("ld_mem_wben", W'(mem_write_back_en), W'(1));
    check_all();
    step();
    chk("ld_wb_we", W'(wb_we), W'(1));
    chk("ld_wb_dest", W'(wb_dest), W'(3));
    chk("ld_wb_data", wb_data, 16'h1234);
    check_all();

    // MEM_LD to r5 held for three cycles, single retirement on release
    set_ex(1'b1, MEM_LD, 1'b0, 4'd5, 16'h0040);
    step();
    set_ex(1'b1, MEM_ST, 1'b1, 4'd6, 16'h7777);
    stall = 1'b1; mem_write_back = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wb_we", W'(wb_we), W'(0));
      chk("stall_mem_alu", mem_alu_result, 16'h0040);
      chk("stall_mem_mode", W'(mem_mode), W'(MEM_LD));
      check_all();
    end
    stall = 1'b0;
    set_ex(1'b0, MEM_NONE, 1'b0, 4'd0, 16'h0);
    step();
    chk("release_wb_we", W'(wb_we), W'(1));
    chk("release_wb_dest", W'(wb_dest), W'(5));
    chk("release_wb_data", wb_data, 16'hCAFE);
    check_all();
    step();
    chk("release_once", W'(wb_we), W'(0));

    // flush while stalled drops the instruction entirely
    set_ex(1'b1, MEM_NONE, 1'b1, 4'd7, 16'h5A5A);
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_mem_valid", W'(mem_valid), W'(0));
    chk("flush_wb_we", W'(wb_we), W'(0));
    check_all();
    stall = 1'b0; flush = 1'b0;
    set_ex(1'b0, MEM_NONE, 1'b0, 4'd0, 16'h0);
    step();
    chk("flush_no_retire", W'(wb_we), W'(0));

    // r2 in flight: MEM match then WB match
    id_rs1 = 4'd2; id_rs1_used = 1'b1; id_rs1_data = 16'h0BAD;
    set_ex(1'b1, MEM_NONE, 1'b1, 4'd2, 16'h5555);
    mem_regfile_we = 1'b1; mem_write_back = 16'h5555;
    step();
    set_ex(1'b0, MEM_NONE, 1'b0, 4'd0, 16'h0);
    #1;
    check_all();
`ifndef DSP_FORWARD_EN
    chk("haz_mem", W'(hazard_stall), W'(1));
`endif
    step();
    #1;
`ifdef DSP_FORWARD_EN
    chk("fwd_wb_only", fwd_rs1_data, 16'h5555);
`else
    chk("haz_wb", W'(hazard_stall), W'(1));
    chk("haz_fwd_pass", fwd_rs1_data, 16'h0BAD);
`endif
    check_all();
    id_rs1_used = 1'b0;
    #1;
    chk("unused_fwd", fwd_rs1_data, 16'h0BAD);
    chk("unused_haz", W'(hazard_stall), W'(0));
    id_rs1_used = 1'b1;
    step();
    chk("haz_cleared", W'(hazard_stall), W'(0));

    // MEM r2=AAAA shadows WB r2=5555
    set_ex(1'b1, MEM_NONE, 1'b1, 4'd2, 16'hAAAA);
    step();
    mem_write_back = 16'h5555;
    step();
    mem_write_back = 16'hAAAA;
    set_ex(1'b0, MEM_NONE, 1'b0, 4'd0, 16'h0);
    #1;
`ifdef DSP_FORWARD_EN
    chk("fwd_mem_wins", fwd_rs1_data, 16'hAAAA);
`else
    chk("haz_both", W'(hazard_stall), W'(1));
`endif
    check_all();

    // randomized traffic over a small register window so matches are frequent
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_ex(1'($urandom), 2'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));
      mem_regfile_we = 1'($urandom);
      mem_write_back = 16'($urandom);
      id_rs1 = 4'($urandom_range(0, 3)); id_rs2 = 4'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_rs1_data = 16'($urandom); id_rs2_data = 16'($urandom);
      #1;
      check_all();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
